// File: rtl/wb_regfile_pkg.sv
// Pipeline-wide write-back types and constants shared by the register file,
// its bus interface and the byte-merge helper.
package wb_regfile_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [3:0]  byte_en_t;
  typedef logic [31:0] word_t;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bundle plus the two ID-stage read ports of the register file.
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  word_t     ALUShift_out_in;
  word_t     Data_in;
  byte_en_t  Rd_write_by_en_in;
  logic      Overflow_in;
  logic      RegWr_in;
  logic      MemtoReg_in;
  reg_addr_t Rd_in;
  reg_addr_t Rs_addr;
  reg_addr_t Rt_addr;
  word_t     busA;
  word_t     busB;
  word_t     wb_data;
  logic      wb_fire;
  word_t     wr_count;

  modport master (
    output ALUShift_out_in, Data_in, Rd_write_by_en_in, Overflow_in,
           RegWr_in, MemtoReg_in, Rd_in, Rs_addr, Rt_addr,
    input  busA, busB, wb_data, wb_fire, wr_count
  );

  modport slave (
    input  ALUShift_out_in, Data_in, Rd_write_by_en_in, Overflow_in,
           RegWr_in, MemtoReg_in, Rd_in, Rs_addr, Rt_addr,
    output busA, busB, wb_data, wb_fire, wr_count
  );

endinterface

// File: rtl/wb_byte_merge.sv
// Byte-lane merge of a new write value over the old register contents;
// lanes whose enable is low keep the old byte.
module wb_byte_merge
  import wb_regfile_pkg::*;
(
  input  word_t    src_i,
  input  word_t    old_i,
  input  byte_en_t be_i,
  output word_t    merged_o
);

  always_comb begin
    merged_o = old_i;
    if (be_i == BE_WORD) begin
      merged_o = src_i;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_i[i]) merged_o[8*i +: 8] = src_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 register file: byte-masked writes on posedge,
// two combinational read ports with same-cycle write-through bypass.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned DW   = 32
) (
  input  logic         clk,
  input  logic         Reset,
  wb_regfile_if.slave  bus
);

  logic [DW-1:0] regs_q [NREG];
  logic [31:0]   wr_count_q;
  logic [31:0]   wr_count_d;
  word_t         src;
  word_t         merged;
  logic          wb_fire;

  assign src = bus.MemtoReg_in ? bus.Data_in : bus.ALUShift_out_in;

  // One merge serves both the committed write and the bypass value.
  wb_byte_merge u_merge (
    .src_i    (src),
    .old_i    (regs_q[bus.Rd_in]),
    .be_i     (bus.Rd_write_by_en_in),
    .merged_o (merged)
  );

  assign wb_fire = bus.RegWr_in & ~bus.Overflow_in & (bus.Rd_in != REG_ZERO)
                 & (bus.Rd_write_by_en_in != '0) & ~Reset;

  assign wr_count_d   = wr_count_q + 32'd1;
  assign bus.wb_fire  = wb_fire;
  assign bus.wb_data  = wb_fire ? merged : '0;
  assign bus.wr_count = wr_count_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      wr_count_q <= '0;
    end else if (wb_fire) begin
      regs_q[bus.Rd_in] <= merged;
      wr_count_q        <= wr_count_d;
    end
  end

  always_comb begin
    bus.busA = '0;
    bus.busB = '0;
    if (bus.Rs_addr != REG_ZERO)
      bus.busA = (wb_fire && bus.Rs_addr == bus.Rd_in) ? merged : regs_q[bus.Rs_addr];
    if (bus.Rt_addr != REG_ZERO)
      bus.busB = (wb_fire && bus.Rt_addr == bus.Rd_in) ? merged : regs_q[bus.Rt_addr];
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboarded bench for wb_regfile: directed write-back scenarios followed
// by a randomized back-to-back stream checked against a reference model.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk   = 1'b0;
  logic Reset = 1'b1;

  wb_regfile_if bif ();

  wb_regfile #(.NREG(32), .DW(32)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct packed {
    logic      rst, regwr, mtr, ovf;
    byte_en_t  be;
    reg_addr_t rd, rs, rt;
    word_t     alu, data;
  } bundle_t;

  typedef struct packed {
    word_t a, b, d;
    logic  f;
    word_t n;
  } obs_t;

  obs_t  exp_q[$];
  word_t model [32];
  word_t model_n;

  // Inputs change on negedge, like the upstream pipeline register.
  task automatic apply(input bundle_t s);
    @(negedge clk);
    Reset                 = s.rst;
    bif.RegWr_in          = s.regwr;
    bif.MemtoReg_in       = s.mtr;
    bif.Overflow_in       = s.ovf;
    bif.Rd_write_by_en_in = s.be;
    bif.Rd_in             = s.rd;
    bif.Rs_addr           = s.rs;
    bif.Rt_addr           = s.rt;
    bif.ALUShift_out_in   = s.alu;
    bif.Data_in           = s.data;
  endtask

  function automatic obs_t observe();
    return '{bif.busA, bif.busB, bif.wb_data, bif.wb_fire, bif.wr_count};
  endfunction

  function automatic bundle_t rd_only(input reg_addr_t rs, input reg_addr_t rt);
    bundle_t s = '0;
    s.rs = rs;
    s.rt = rt;
    return s;
  endfunction

  task automatic test_reset();
    obs_t got, exp;
    bundle_t s = '0;
    s.rst = 1'b1;
    apply(s);
    for (int r = 0; r < 32; r++) begin
      apply(rd_only(reg_addr_t'(r), reg_addr_t'(31 - r)));
      exp_q.push_back('{32'h0, 32'h0, 32'h0, 1'b0, 32'd0});
      #1;
      got = observe();
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_read r=%0d: got %h want %h", r, got, exp);
      end
    end
  endtask

  task automatic test_full_write_bypass();
    obs_t got, exp;
    bundle_t st [2];
    obs_t    ex [2];
    st[0] = '0; st[0].regwr = 1; st[0].alu = 32'h12345678; st[0].data = 32'hCAFEF00D;
    st[0].be = 4'hF; st[0].rd = 5; st[0].rs = 5; st[0].rt = 5;
    ex[0] = '{32'h12345678, 32'h12345678, 32'h12345678, 1'b1, 32'd0};
    st[1] = rd_only(5, 5);
    ex[1] = '{32'h12345678, 32'h12345678, 32'h0, 1'b0, 32'd1};
    for (int i = 0; i < 2; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #1;
      got = observe();
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL full_write step=%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_partial_write();
    obs_t got, exp;
    bundle_t st [4];
    obs_t    ex [4];
    st[0] = '0; st[0].regwr = 1; st[0].mtr = 1; st[0].data = 32'hAABBCCDD;
    st[0].alu = 32'hDEADBEEF; st[0].be = 4'b0011; st[0].rd = 5; st[0].rs = 5;
    ex[0] = '{32'h1234CCDD, 32'h0, 32'h1234CCDD, 1'b1, 32'd1};
    st[1] = rd_only(5, 0);
    ex[1] = '{32'h1234CCDD, 32'h0, 32'h0, 1'b0, 32'd2};
    st[2] = st[0]; st[2].be = 4'b1100; st[2].rt = 5;
    ex[2] = '{32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 1'b1, 32'd2};
    st[3] = rd_only(5, 5);
    ex[3] = '{32'hAABBCCDD, 32'hAABBCCDD, 32'h0, 1'b0, 32'd3};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #1;
      got = observe();
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL partial_write step=%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_blocked_writes();
    obs_t got, exp;
    bundle_t st [5];
    obs_t    ex [5];
    st[0] = '0; st[0].regwr = 1; st[0].alu = 32'hFFFFFFFF; st[0].be = 4'hF;
    st[0].rd = 0; st[0].rs = 0; st[0].rt = 5;
    ex[0] = '{32'h0, 32'hAABBCCDD, 32'h0, 1'b0, 32'd3};
    st[1] = rd_only(0, 0);
    ex[1] = '{32'h0, 32'h0, 32'h0, 1'b0, 32'd3};
    st[2] = '0; st[2].regwr = 1; st[2].ovf = 1; st[2].alu = 32'h1; st[2].be = 4'hF;
    st[2].rd = 7; st[2].rs = 5; st[2].rt = 7;
    ex[2] = '{32'hAABBCCDD, 32'h0, 32'h0, 1'b0, 32'd3};
    st[3] = '0; st[3].regwr = 1; st[3].alu = 32'h77; st[3].be = 4'h0;
    st[3].rd = 7; st[3].rt = 7;
    ex[3] = '{32'h0, 32'h0, 32'h0, 1'b0, 32'd3};
    st[4] = rd_only(7, 7);
    ex[4] = '{32'h0, 32'h0, 32'h0, 1'b0, 32'd3};
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #1;
      got = observe();
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL blocked_write step=%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_during_write();
    obs_t got, exp;
    bundle_t st [4];
    obs_t    ex [4];
    st[0] = '0; st[0].regwr = 1; st[0].alu = 32'h55; st[0].be = 4'hF;
    st[0].rd = 3; st[0].rs = 3;
    ex[0] = '{32'h55, 32'h0, 32'h55, 1'b1, 32'd3};
    st[1] = st[0]; st[1].rst = 1; st[1].alu = 32'h99; st[1].rt = 3;
    ex[1] = '{32'h55, 32'h55, 32'h0, 1'b0, 32'd4};
    st[2] = rd_only(3, 5);
    ex[2] = '{32'h0, 32'h0, 32'h0, 1'b0, 32'd0};
    st[3] = rd_only(3, 3);
    ex[3] = '{32'h0, 32'h0, 32'h0, 1'b0, 32'd0};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #1;
      got = observe();
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_during_write step=%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  // Reference model: predicts this cycle's outputs and commits the write.
  function automatic obs_t predict(input bundle_t s);
    obs_t  o;
    word_t src, mrg;
    logic  fire;
    src  = s.mtr ? s.data : s.alu;
    mrg  = model[s.rd];
    for (int k = 0; k < 4; k++) if (s.be[k]) mrg[8*k +: 8] = src[8*k +: 8];
    fire = s.regwr && !s.ovf && s.rd != 0 && s.be != 0;
    o.a  = (s.rs == 0) ? 32'h0 : (fire && s.rs == s.rd) ? mrg : model[s.rs];
    o.b  = (s.rt == 0) ? 32'h0 : (fire && s.rt == s.rd) ? mrg : model[s.rt];
    o.d  = fire ? mrg : 32'h0;
    o.f  = fire;
    o.n  = model_n;
    if (fire) begin
      model[s.rd] = mrg;
      model_n     = model_n + 1;
    end
    return o;
  endfunction

  task automatic test_back_to_back();
    obs_t    got, exp;
    bundle_t s;
    for (int i = 0; i < 32; i++) model[i] = '0;
    model_n = 0;
    for (int i = 0; i < 80; i++) begin
      s       = '0;
      s.regwr = ($urandom_range(0, 3) != 0);
      s.mtr   = 1'($urandom_range(0, 1));
      s.ovf   = ($urandom_range(0, 7) == 0);
      s.be    = 4'($urandom_range(0, 15));
      s.rd    = 5'($urandom_range(0, 7));
      s.rs    = ($urandom_range(0, 2) == 0) ? s.rd : 5'($urandom_range(0, 7));
      s.rt    = ($urandom_range(0, 2) == 0) ? s.rd : 5'($urandom_range(0, 7));
      s.alu   = $urandom;
      s.data  = $urandom;
      apply(s);
      exp_q.push_back(predict(s));
      #1;
      got = observe();
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL back_to_back i=%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  initial begin
    bif.RegWr_in          = 1'b0;
    bif.MemtoReg_in       = 1'b0;
    bif.Overflow_in       = 1'b0;
    bif.Rd_write_by_en_in = '0;
    bif.Rd_in             = '0;
    bif.Rs_addr           = '0;
    bif.Rt_addr           = '0;
    bif.ALUShift_out_in   = '0;
    bif.Data_in           = '0;
    test_reset();
    test_full_write_bypass();
    test_partial_write();
    test_blocked_writes();
    test_reset_during_write();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline register, plus the 32x32 general-purpose register file that it writes into.
- Consumes the registered write-back bundle: ALU/shift result, memory load data, byte enables, overflow flag, RegWr, MemtoReg and Rd.
- Selects the write-back value and performs byte-masked writes into the register file.
- Serves the two ID-stage read ports, with same-cycle write-through bypass.

Parameters:
- NREG, 32, number of architectural registers (address width = log2(NREG) = 5).
- DW, 32, data width; must be 32 (4 byte lanes).

Ports:
- clk  in  1  clock; register file writes on posedge.
- Reset  in  1  reset; synchronous, active-high.
- ALUShift_out_in  in  32  ALU/shifter result from MEM/WB.
- Data_in  in  32  memory load data from MEM/WB.
- Rd_write_by_en_in  in  4  byte-lane write enables; bit i covers bits [8i+7:8i].
- Overflow_in  in  1  arithmetic overflow flag; suppresses the write.
- RegWr_in  in  1  register write request.
- MemtoReg_in  in  1  1 = write Data_in, 0 = write ALUShift_out_in.
- Rd_in  in  5  destination register.
- Rs_addr  in  5  read port A address.
- Rt_addr  in  5  read port B address.
- busA  out  32  read port A data.
- busB  out  32  read port B data.
- wb_data  out  32  merged value being written this cycle (0 when no write).
- wb_fire  out  1  a write commits at the next posedge.
- wr_count  out  32  number of committed writes since reset.

Behaviour:
- Source select: src = MemtoReg_in ? Data_in : ALUShift_out_in.
- Write qualify: wb_fire = RegWr_in & ~Overflow_in & (Rd_in != 0) & (Rd_write_by_en_in != 0) & ~Reset.
- Merge: merged byte i = Rd_write_by_en_in[i] ? src byte i : regs[Rd_in] byte i. Disabled lanes keep their old contents.
- wb_data = wb_fire ? merged : 32'h0. Combinational.
- Posedge clk:
  - If Reset: all regs[0..31] <= 0 and wr_count <= 0.
  - Else if wb_fire: regs[Rd_in] <= merged and wr_count <= wr_count + 1.
  - Else: everything holds.
- wr_count wraps from 32'hFFFFFFFF to 0.
- Register 0:
  - Always reads 0.
  - A write to Rd = 0 is dropped and does not count.
  - Storage for register 0 may be omitted.
- Reads (combinational):
  - busA = (Rs_addr == 0) ? 0 : (wb_fire & Rs_addr == Rd_in) ? merged : regs[Rs_addr].
  - busB is identical, using Rt_addr.
  - The bypass means an instruction in ID sees the value written by WB in the same cycle.
- Timing: the upstream pipeline register updates on negedge. Inputs are therefore stable for the half-cycle before the posedge write. Write latency is one posedge.
- Reset values: busA/busB = 0 for every address after reset; wb_data = 0, wb_fire = 0, wr_count = 0.
- Reset held during a valid write bundle: the write is blocked, not counted and not bypassed.
- Overflow_in = 1 with RegWr_in = 1: no write, no bypass, wb_fire = 0.
- Byte enables of 4'b0000 with RegWr_in = 1: treated as no write.
- Full-word writes use 4'b1111.
- Simultaneous reads of the same register on A and B: both return the same (bypassed) value.

Decomposition:
- Shared package (pipeline-wide):
  - REG_ZERO = 5'd0.
  - BE_WORD = 4'b1111.
  - Typedef for the 5-bit register address.
  - Typedef for the 4-bit byte-enable vector.
- Sub-module: wb_byte_merge. Purely combinational: src, old, be -> merged. It is reused by the bypass path and the write path.
- The storage array and counter stay in wb_regfile.

Test Plan:
- Reset, then read all 32 addresses -> busA = busB = 0; wr_count = 0.
- RegWr=1, MemtoReg=0, ALUShift=32'h12345678, be=4'hF, Rd=5, Rs=5 in the same cycle -> busA = 32'h12345678 before the edge (bypass); regs[5] holds it after the posedge; wr_count = 1.
- Partial write, with regs[5] = 32'h12345678: MemtoReg=1, Data=32'hAABBCCDD, be=4'b0011, Rd=5 -> regs[5] = 32'h1234CCDD; be=4'b1100 with the same data -> 32'hAABBCCDD.
- Write to Rd=0 with data 32'hFFFFFFFF, be=4'hF, RegWr=1 -> busA (Rs=0) = 0, wb_fire = 0, wr_count unchanged.
- Overflow=1, RegWr=1, Rd=7, data 32'h1 -> regs[7] unchanged (0), wb_fire = 0, no bypass on busB (Rt=7).
- Reset asserted while a valid write targets Rd=3 with regs[3] = 32'h55 -> regs[3] = 0 and wr_count = 0 after the edge; the write is lost.
